// File: rtl/ro_scan_ctrl_if.sv
// Result channel of the RO scan sequencer: one {index, count, overflow} record per measured RO.
// valid/ready: the producer holds res_valid and the payload stable until the cycle where res_valid & res_ready are both high.
interface ro_scan_ctrl_if #(
  parameter int IDX_W = 8,
  parameter int CNT_W = 16
);
  logic             res_valid;
  logic             res_ready;
  logic [IDX_W-1:0] res_idx;
  logic [CNT_W-1:0] res_count;
  logic             res_ovf;

  modport master (output res_valid, res_idx, res_count, res_ovf, input res_ready);
  modport slave  (input res_valid, res_idx, res_count, res_ovf, output res_ready);
endinterface

// File: rtl/ro_scan_ctrl.sv
// Ring-oscillator scan sequencer: enable one RO, settle, count prescaled edges over a
// fixed gate window, and report {index, count, overflow} on a valid/ready channel.
module ro_scan_ctrl #(
  parameter int NUM_RO        = 190,
  parameter int IDX_W         = 8,
  parameter int CNT_W         = 16,
  parameter int GATE_CYCLES   = 4096,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              scan_all,
  input  logic [IDX_W-1:0]  start_idx,
  input  logic              abort,
  output logic [NUM_RO-1:0] ro_en,
  output logic [IDX_W-1:0]  ro_sel,
  input  logic              ro_meas,
  ro_scan_ctrl_if.master    res,
  output logic              busy,
  output logic              done,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {IDLE, SETTLE, GATE, REPORT} state_t;

  localparam int PH_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX);
  localparam logic [IDX_W-1:0] LAST_RO   = IDX_W'(NUM_RO - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [PH_W-1:0]  SETTLE_LD = PH_W'(SETTLE_CYCLES - 1);
  localparam logic [PH_W-1:0]  GATE_LD   = PH_W'(GATE_CYCLES - 1);

  state_t           state, state_nx;
  logic [IDX_W-1:0] idx, last, start_clamped;
  logic [PH_W-1:0]  phase;
  logic [CNT_W-1:0] count;
  logic             ovf;
  logic             meas_s1, meas_s2, meas_d, meas_rise;
  logic             handshake;

  assign start_clamped = (start_idx > LAST_RO) ? LAST_RO : start_idx;
  assign handshake     = (state == REPORT) && res.res_ready;

  // The edge history tracks the synced level continuously, so whatever level is
  // present when the gate opens is never mistaken for an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meas_s1 <= 1'b0;
      meas_s2 <= 1'b0;
      meas_d  <= 1'b0;
    end else begin
      meas_s1 <= ro_meas;
      meas_s2 <= meas_s1;
      meas_d  <= meas_s2;
    end
  end
  assign meas_rise = meas_s2 & ~meas_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // abort outranks start in IDLE and the handshake in REPORT
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start && !abort) state_nx = SETTLE;
      SETTLE:  if (abort) state_nx = IDLE; else if (phase == '0) state_nx = GATE;
      GATE:    if (abort) state_nx = IDLE; else if (phase == '0) state_nx = REPORT;
      REPORT:  if (abort) state_nx = IDLE;
               else if (handshake) state_nx = (idx == last) ? IDLE : SETTLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= '0;
      last  <= '0;
      phase <= '0;
      count <= '0;
      ovf   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= (state != IDLE) && (state_nx == IDLE);
      case (state)
        IDLE: if (state_nx == SETTLE) begin
          idx   <= scan_all ? '0 : start_clamped;
          last  <= scan_all ? LAST_RO : start_clamped;
          phase <= SETTLE_LD;
          count <= '0;
          ovf   <= 1'b0;
        end
        SETTLE: begin
          if (state_nx == GATE)  phase <= GATE_LD;
          else if (phase != '0) phase <= phase - PH_W'(1);
        end
        GATE: begin
          if (phase != '0) phase <= phase - PH_W'(1);
          if (meas_rise && count != CNT_MAX) begin
            count <= count + CNT_W'(1);
            if (count == CNT_MAX - CNT_W'(1)) ovf <= 1'b1;
          end
        end
        REPORT: if (state_nx == SETTLE) begin
          idx   <= idx + IDX_W'(1);
          phase <= SETTLE_LD;
          count <= '0;
          ovf   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ro_en = '0;
    for (int i = 0; i < NUM_RO; i++)
      ro_en[i] = ((state == SETTLE) || (state == GATE)) && (idx == IDX_W'(i));
  end

  assign ro_sel        = (state == IDLE) ? '0 : idx;
  assign busy          = (state != IDLE);
  assign state_dbg     = state;
  assign res.res_valid = (state == REPORT);
  assign res.res_idx   = (state == REPORT) ? idx : '0;
  assign res.res_count = (state == REPORT) ? count : '0;
  assign res.res_ovf   = (state == REPORT) && ovf;

endmodule

// File: tb/tb_ro_scan_ctrl.sv
// Directed bench for ro_scan_ctrl: a full-size instance (190 ROs, 4096-cycle gate) and a
// small instance (4 ROs, 4-bit count, 256-cycle gate) for scans, saturation and abort.
module tb_ro_scan_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // full-size instance
  logic         start_a = 0, scan_a = 0, abort_a = 0, meas_a = 0;
  logic [7:0]   sidx_a = 0;
  logic [189:0] ro_en_a;
  logic [7:0]   ro_sel_a;
  logic         busy_a, done_a;
  logic [1:0]   dbg_a;
  ro_scan_ctrl_if #(.IDX_W(8), .CNT_W(16)) res_a ();

  ro_scan_ctrl #(.NUM_RO(190), .IDX_W(8), .CNT_W(16), .GATE_CYCLES(4096), .SETTLE_CYCLES(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .scan_all(scan_a), .start_idx(sidx_a),
    .abort(abort_a), .ro_en(ro_en_a), .ro_sel(ro_sel_a), .ro_meas(meas_a), .res(res_a),
    .busy(busy_a), .done(done_a), .state_dbg(dbg_a));

  // small instance
  logic       start_b = 0, scan_b = 0, abort_b = 0, meas_b = 0;
  logic [3:0] sidx_b = 0;
  logic [3:0] ro_en_b;
  logic [3:0] ro_sel_b;
  logic       busy_b, done_b;
  logic [1:0] dbg_b;
  ro_scan_ctrl_if #(.IDX_W(4), .CNT_W(4)) res_b ();

  ro_scan_ctrl #(.NUM_RO(4), .IDX_W(4), .CNT_W(4), .GATE_CYCLES(256), .SETTLE_CYCLES(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .scan_all(scan_b), .start_idx(sidx_b),
    .abort(abort_b), .ro_en(ro_en_b), .ro_sel(ro_sel_b), .ro_meas(meas_b), .res(res_b),
    .busy(busy_b), .done(done_b), .state_dbg(dbg_b));

  // ro_meas sources: div 0 = low, 1 = high, else square wave of period div clk cycles
  int div_a = 0, div_b = 0, ph_a = 0, ph_b = 0;
  always @(negedge clk) begin
    if (div_a < 2) meas_a = div_a[0];
    else begin
      ph_a++;
      if (ph_a >= div_a / 2) begin ph_a = 0; meas_a = ~meas_a; end
    end
    if (div_b < 2) meas_b = div_b[0];
    else begin
      ph_b++;
      if (ph_b >= div_b / 2) begin ph_b = 0; meas_b = ~meas_b; end
    end
  end

  int done_cnt_b = 0;
  always @(negedge clk) if (done_b) done_cnt_b++;

  always @(negedge clk) begin
    if (rst_n && (busy_a || busy_b)) begin
      total++;
      if ($countones(ro_en_a) > 1 || $countones(ro_en_b) > 1) begin
        bad++;
        $display("FAIL onehot: ro_en_a=%h ro_en_b=%b, at most one bit required", ro_en_a, ro_en_b);
      end
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input longint act, input longint lo, input longint hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic start_a_run(input bit sa, input logic [7:0] si);
    @(posedge clk); #1 start_a = 1; scan_a = sa; sidx_a = si;
    @(posedge clk); #1 start_a = 0;
  endtask

  task automatic start_b_run(input bit sa, input logic [3:0] si);
    @(posedge clk); #1 start_b = 1; scan_b = sa; sidx_b = si;
    @(posedge clk); #1 start_b = 0;
  endtask

  task automatic wait_valid_a(output int lat);
    bit ok = 0;
    lat = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk); lat++;
      if (res_a.res_valid) begin ok = 1; break; end
    end
    check("a_valid_timeout", ok, 1);
  endtask

  task automatic wait_valid_b(output int lat);
    bit ok = 0;
    lat = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk); lat++;
      if (res_b.res_valid) begin ok = 1; break; end
    end
    check("b_valid_timeout", ok, 1);
  endtask

  task automatic accept_a();
    res_a.res_ready = 1; @(posedge clk); #1 res_a.res_ready = 0;
  endtask

  task automatic accept_b();
    res_b.res_ready = 1; @(posedge clk); #1 res_b.res_ready = 0;
  endtask

  typedef struct {
    logic [3:0] sidx;
    int         div;
    int         exp_idx;
    int         cnt_lo;
    int         cnt_hi;
    bit         exp_ovf;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int lat;
    int seen;
    bit stable;
    logic [3:0] c_idx, c_cnt;
    logic c_ovf;
    logic [189:0] one_a;

    vecs[0] = '{sidx: 4'd1, div: 8,  exp_idx: 1, cnt_lo: 15, cnt_hi: 15, exp_ovf: 1};
    vecs[1] = '{sidx: 4'd9, div: 0,  exp_idx: 3, cnt_lo: 0,  cnt_hi: 0,  exp_ovf: 0};
    vecs[2] = '{sidx: 4'd2, div: 64, exp_idx: 2, cnt_lo: 3,  cnt_hi: 5,  exp_ovf: 0};
    vecs[3] = '{sidx: 4'd0, div: 4,  exp_idx: 0, cnt_lo: 15, cnt_hi: 15, exp_ovf: 1};
    vecs[4] = '{sidx: 4'd3, div: 32, exp_idx: 3, cnt_lo: 7,  cnt_hi: 9,  exp_ovf: 0};
    vecs[5] = '{sidx: 4'd2, div: 1,  exp_idx: 2, cnt_lo: 0,  cnt_hi: 0,  exp_ovf: 0};
    res_a.res_ready = 0;
    res_b.res_ready = 0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_ro_en_a", ro_en_a, 0);
    check("rst_busy_a", busy_a, 0);
    check("rst_done_a", done_a, 0);
    check("rst_valid_a", res_a.res_valid, 0);
    check("rst_sel_b", ro_sel_b, 0);
    check("rst_count_b", res_b.res_count, 0);
    @(negedge clk) rst_n = 1;

    // reset mid-gate with ro_en[5] set
    div_a = 8;
    start_a_run(0, 8'd5);
    repeat (66) @(negedge clk);
    one_a = 1;
    check("t1_state_gate", dbg_a, 2);
    check("t1_ro_en5", ro_en_a == (one_a << 5), 1);
    #2 rst_n = 0;
    #1;
    check("t1_async_ro_en", ro_en_a, 0);
    check("t1_async_busy", busy_a, 0);
    check("t1_async_valid", res_a.res_valid, 0);
    @(negedge clk) rst_n = 1;

    // single measurement of RO 7 at clk/8
    start_a_run(0, 8'd7);
    wait_valid_a(lat);
    check("t2_latency", lat, 16 + 4096 + 1);
    check("t2_idx", res_a.res_idx, 7);
    check_rng("t2_count", res_a.res_count, 511, 513);
    check("t2_ovf", res_a.res_ovf, 0);
    check("t2_ro_en_off", ro_en_a, 0);
    accept_a();
    @(negedge clk);
    check("t2_done", done_a, 1);
    check("t2_busy", busy_a, 0);
    @(negedge clk);
    check("t2_done_pulse", done_a, 0);

    // out-of-range index clamps to the last RO; a start while busy is ignored
    div_a = 0;
    start_a_run(0, 8'd250);
    @(negedge clk);
    check("t6_ro_en189", ro_en_a == (one_a << 189), 1);
    check("t6_sel", ro_sel_a, 189);
    start_a_run(1, 8'd3);
    @(negedge clk);
    check("t6_sel_after_restart", ro_sel_a, 189);
    check("t6_ro_en_after_restart", ro_en_a == (one_a << 189), 1);
    wait_valid_a(lat);
    check("t6_idx", res_a.res_idx, 189);
    check("t6_count", res_a.res_count, 0);
    accept_a();
    @(negedge clk);
    check("t6_done", done_a, 1);

    // table of single runs on the small instance
    for (int v = 0; v < 6; v++) begin
      div_b = vecs[v].div;
      repeat (20) @(negedge clk);
      start_b_run(0, vecs[v].sidx);
      wait_valid_b(lat);
      check($sformatf("v%0d_latency", v), lat, 4 + 256 + 1);
      check($sformatf("v%0d_idx", v), res_b.res_idx, vecs[v].exp_idx);
      check_rng($sformatf("v%0d_count", v), res_b.res_count, vecs[v].cnt_lo, vecs[v].cnt_hi);
      check($sformatf("v%0d_ovf", v), res_b.res_ovf, vecs[v].exp_ovf);
      check($sformatf("v%0d_ro_en_off", v), ro_en_b, 0);
      accept_b();
      @(negedge clk);
      check($sformatf("v%0d_done", v), done_b, 1);
      check($sformatf("v%0d_busy", v), busy_b, 0);
    end

    // full scan with 10 stall cycles per result
    div_b = 64;
    repeat (5) @(negedge clk);
    done_cnt_b = 0;
    start_b_run(1, 4'd2);
    for (int k = 0; k < 4; k++) begin
      wait_valid_b(lat);
      check($sformatf("scan%0d_idx", k), res_b.res_idx, k);
      c_idx = res_b.res_idx; c_cnt = res_b.res_count; c_ovf = res_b.res_ovf;
      stable = 1;
      for (int s = 0; s < 10; s++) begin
        @(negedge clk);
        if (!res_b.res_valid || res_b.res_idx !== c_idx || res_b.res_count !== c_cnt ||
            res_b.res_ovf !== c_ovf) stable = 0;
      end
      check($sformatf("scan%0d_stable", k), stable, 1);
      check_rng($sformatf("scan%0d_count", k), c_cnt, 3, 5);
      accept_b();
    end
    repeat (4) @(negedge clk);
    check("scan_done_once", done_cnt_b, 1);
    check("scan_idle", busy_b, 0);

    // abort in the settle phase of RO 2
    div_b = 0;
    done_cnt_b = 0;
    start_b_run(1, 4'd0);
    for (int k = 0; k < 2; k++) begin
      wait_valid_b(lat);
      accept_b();
    end
    check("t5_sel2", ro_sel_b, 2);
    check("t5_settle", dbg_b, 1);
    abort_b = 1;
    @(posedge clk); #1 abort_b = 0;
    @(negedge clk);
    check("t5_busy", busy_b, 0);
    check("t5_ro_en", ro_en_b, 0);
    check("t5_valid", res_b.res_valid, 0);
    check("t5_done", done_b, 1);
    seen = 0;
    repeat (300) @(negedge clk) if (res_b.res_valid) seen++;
    check("t5_no_result", seen, 0);
    check("t5_done_once", done_cnt_b, 1);

    // start and abort together in IDLE: nothing starts
    @(posedge clk); #1 start_b = 1; abort_b = 1; scan_b = 0; sidx_b = 1;
    @(posedge clk); #1 start_b = 0; abort_b = 0;
    @(negedge clk);
    check("sa_busy", busy_b, 0);
    repeat (3) @(negedge clk);
    check("sa_state", dbg_b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
